// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    // One-hot owner encodings; also the output encoding of rr_pick2.
    localparam logic [1:0] GRANT_IF = 2'b01;
    localparam logic [1:0] GRANT_D  = 2'b10;

    // Default read latency of the unified memory, in cycles.
    localparam int unsigned DEF_MEM_LATENCY = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester always wins, a tie goes to
// whichever requester was not granted last.
module rr_pick2
    import cpu_pkg::*;
(
    input  logic [1:0] req,   // bit0 = fetch, bit1 = data
    input  logic       last,  // 1 = data was granted last, 0 = fetch was
    output logic [1:0] pick   // one-hot winner, 00 when nobody requests
);

    // Decode the request pair into a one-hot winner.
    always_comb begin
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = GRANT_IF;
            2'b10:   pick = GRANT_D;
            2'b11:   pick = last ? GRANT_IF : GRANT_D;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between the instruction-fetch port and the data
// port. Each req/ack handshake becomes a single registered read or write strobe; read
// data is captured MEM_LATENCY edges after the strobe edge and handed back with a
// one-cycle ack.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY  // legal range 1..7
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        grant
);

    // WAIT is entered after the ISSUE edge, so it still has MEM_LATENCY-1 edges to go.
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

    arb_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_q, last_d;        // 1 = data port owned the last transaction
    logic [1:0]        grant_q, grant_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        pick;
    logic              rd_done;

    rr_pick2 u_pick (
        .req  ({d_req, if_req}),
        .last (last_q),
        .pick (pick)
    );

    // State register; reset abandons any transaction and drops strobes immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, strobe in ISSUE, count latency in WAIT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        rd_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ISSUE;
                    grant_d = pick;
                    last_d  = pick[1];
                    if (pick == GRANT_D) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_we;
                        mem_re_d    = ~d_we;
                    end else begin
                        // Fetch port is read-only.
                        mem_addr_d = if_addr;
                        mem_re_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = ACK;
                    d_ack_d = 1'b1;
                end else if (MEM_LATENCY == 1) begin
                    rd_done = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    rd_done = 1'b1;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                // req is deliberately ignored here so a held req is seen fresh in IDLE.
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        // Read completion: capture into the owner's data register and ack it.
        if (rd_done) begin
            state_d = ACK;
            if (grant_q == GRANT_D) begin
                d_rdata_d = mem_rdata;
                d_ack_d   = 1'b1;
            end else begin
                if_rdata_d = mem_rdata;
                if_ack_d   = 1'b1;
            end
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a runs with MEM_LATENCY = 1, dut_b with MEM_LATENCY = 3.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    // dut_a (latency 1)
    logic        a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack, a_mem_re, a_mem_we;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_mem_val;
    logic [1:0]  a_grant;

    // dut_b (latency 3)
    logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_re, b_mem_we;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_mem_val;
    logic [1:0]  b_grant;
    logic [2:0]  b_age;

    int n_checks;
    int n_pass;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .if_req    (a_if_req),
        .if_addr   (a_if_addr),
        .if_ack    (a_if_ack),
        .if_rdata  (a_if_rdata),
        .d_req     (a_d_req),
        .d_we      (a_d_we),
        .d_addr    (a_d_addr),
        .d_wdata   (a_d_wdata),
        .d_ack     (a_d_ack),
        .d_rdata   (a_d_rdata),
        .mem_addr  (a_mem_addr),
        .mem_wdata (a_mem_wdata),
        .mem_re    (a_mem_re),
        .mem_we    (a_mem_we),
        .mem_rdata (a_mem_rdata),
        .grant     (a_grant)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .if_req    (b_if_req),
        .if_addr   (b_if_addr),
        .if_ack    (b_if_ack),
        .if_rdata  (b_if_rdata),
        .d_req     (b_d_req),
        .d_we      (b_d_we),
        .d_addr    (b_d_addr),
        .d_wdata   (b_d_wdata),
        .d_ack     (b_d_ack),
        .d_rdata   (b_d_rdata),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_re    (b_mem_re),
        .mem_we    (b_mem_we),
        .mem_rdata (b_mem_rdata),
        .grant     (b_grant)
    );

    always #5 clk = ~clk;

    // Latency-1 memory: data valid only while the strobe is up.
    assign a_mem_rdata = a_mem_re ? a_mem_val : 32'hBAD0BAD0;

    // Latency-3 memory: data valid only in the cycle just before edge E3.
    always @(posedge clk or negedge reset) begin
        if (!reset)                       b_age <= 3'd0;
        else if (b_mem_re)                b_age <= 3'd1;
        else if (b_age != 3'd0 && b_age < 3'd7) b_age <= b_age + 3'd1;
        else                              b_age <= 3'd0;
    end
    assign b_mem_rdata = (b_age == 3'd2) ? b_mem_val : 32'hBAD0BAD0;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_val;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int re_cnt, ack_cnt, bad_gap, bad_data, bad_addr, last_re, ack_at, re_n;
        logic [1:0] g_wait;
        logic [1:0] g_exp;

        n_checks = 0;
        n_pass   = 0;
        clk      = 1'b0;
        reset    = 1'b0;
        {a_if_req, a_d_req, a_d_we} = '0;
        {b_if_req, b_d_req, b_d_we} = '0;
        a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_mem_val = '0;
        b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_val = '0;

        // fetch/data, we, addr, wdata, mem value, expected if_rdata, expected d_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h8C010004, 32'h8C010004, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0,        32'h8C010004, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h0,        32'h12345678, 32'h8C010004, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h28, 32'hCAFEF00D, 32'h0,        32'h8C010004, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'h00000013, 32'h00000013, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h2C, 32'h0,        32'hA5A5A5A5, 32'h00000013, 32'hA5A5A5A5};

        // Reset values, before any clock edge.
        #1;
        check("rst_grant",  64'(a_grant), 64'd0);
        check("rst_strobe", 64'({a_mem_re, a_mem_we, b_mem_re, b_mem_we}), 64'd0);
        check("rst_ack",    64'({a_if_ack, a_d_ack, b_if_ack, b_d_ack}), 64'd0);
        check("rst_addr",   64'(a_mem_addr), 64'd0);
        check("rst_wdata",  64'(a_mem_wdata), 64'd0);
        check("rst_rdata",  64'({a_if_rdata, a_d_rdata}), 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // Single transactions on the latency-1 port.
        for (int i = 0; i < 6; i++) begin
            a_mem_val = vecs[i].mem_val;
            if (vecs[i].is_data) begin
                a_d_req = 1'b1; a_d_we = vecs[i].we;
                a_d_addr = vecs[i].addr; a_d_wdata = vecs[i].wdata;
            end else begin
                a_if_req = 1'b1; a_if_addr = vecs[i].addr;
            end
            g_exp = vecs[i].is_data ? 2'b10 : 2'b01;
            tick();  // E0
            check($sformatf("v%0d_mem_re", i), 64'(a_mem_re),
                  64'(!(vecs[i].is_data && vecs[i].we)));
            check($sformatf("v%0d_mem_we", i), 64'(a_mem_we), 64'(vecs[i].is_data && vecs[i].we));
            check($sformatf("v%0d_mem_addr", i), 64'(a_mem_addr), 64'(vecs[i].addr));
            if (vecs[i].we)
                check($sformatf("v%0d_mem_wdata", i), 64'(a_mem_wdata), 64'(vecs[i].wdata));
            check($sformatf("v%0d_grant_issue", i), 64'(a_grant), 64'(g_exp));
            check($sformatf("v%0d_ack_early", i), 64'({a_if_ack, a_d_ack}), 64'd0);
            tick();  // E1
            check($sformatf("v%0d_strobe_clr", i), 64'({a_mem_re, a_mem_we}), 64'd0);
            check($sformatf("v%0d_ack", i), 64'({a_d_ack, a_if_ack}), 64'(g_exp));
            check($sformatf("v%0d_grant_ack", i), 64'(a_grant), 64'(g_exp));
            check($sformatf("v%0d_if_rdata", i), 64'(a_if_rdata), 64'(vecs[i].exp_if_rdata));
            check($sformatf("v%0d_d_rdata", i), 64'(a_d_rdata), 64'(vecs[i].exp_d_rdata));
            a_if_req = 1'b0; a_d_req = 1'b0;
            tick();  // E2
            check($sformatf("v%0d_ack_done", i), 64'({a_if_ack, a_d_ack}), 64'd0);
            check($sformatf("v%0d_grant_idle", i), 64'(a_grant), 64'd0);
        end

        // Held tie after reset: F, D, F, D.
        pulse_reset();
        a_if_addr = 32'h30; a_d_addr = 32'h40; a_d_we = 1'b0; a_mem_val = 32'h77;
        a_if_req = 1'b1; a_d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("tie%0d_grant", k), 64'(a_grant), 64'(g_exp));
            check($sformatf("tie%0d_addr", k), 64'(a_mem_addr),
                  (k % 2 == 0) ? 64'h30 : 64'h40);
            tick();
            check($sformatf("tie%0d_ack", k), 64'({a_d_ack, a_if_ack}), 64'(g_exp));
            if (k == 3) begin
                a_if_req = 1'b0; a_d_req = 1'b0;
            end
            tick();
        end
        check("tie_rdata", 64'({a_if_rdata, a_d_rdata}), 64'h00000077_00000077);

        // Continuous fetch stream of 10 requests.
        re_cnt = 0; ack_cnt = 0; bad_gap = 0; bad_data = 0; bad_addr = 0; last_re = -1;
        a_if_addr = 32'h100; a_mem_val = 32'h10000000; a_if_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_mem_re) begin
                if (last_re >= 0 && c - last_re != 3) bad_gap++;
                if (a_mem_addr !== 32'h100 + 32'(4 * re_cnt)) bad_addr++;
                last_re = c;
                re_cnt++;
            end
            if (a_if_ack) begin
                ack_cnt++;
                if (a_if_rdata !== a_mem_val) bad_data++;
                a_if_addr = a_if_addr + 32'd4;
                a_mem_val = a_mem_val + 32'd1;
                if (ack_cnt == 10) a_if_req = 1'b0;
            end
        end
        check("stream_re_count",  64'(re_cnt), 64'd10);
        check("stream_ack_count", 64'(ack_cnt), 64'd10);
        check("stream_bad_gap",   64'(bad_gap), 64'd0);
        check("stream_bad_addr",  64'(bad_addr), 64'd0);
        check("stream_bad_data",  64'(bad_data), 64'd0);

        // Latency-3 data read.
        b_d_we = 1'b0; b_d_addr = 32'h50; b_mem_val = 32'h42; b_d_req = 1'b1;
        ack_at = -1; re_n = 0; g_wait = 2'b00;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (b_mem_re) re_n++;
            if (e == 2) g_wait = b_grant;
            if (b_d_ack && ack_at < 0) begin
                ack_at = e;
                b_d_req = 1'b0;
            end
        end
        check("l3_ack_edge", 64'(ack_at), 64'd3);
        check("l3_re_count", 64'(re_n), 64'd1);
        check("l3_grant_wait", 64'(g_wait), 64'(2'b10));
        check("l3_d_rdata", 64'(b_d_rdata), 64'h42);

        // Reset while waiting on a latency-3 fetch.
        b_if_addr = 32'h60; b_mem_val = 32'h99; b_if_req = 1'b1;
        tick();  // E0
        tick();  // E1, now in WAIT
        check("rw_grant_before", 64'(b_grant), 64'(2'b01));
        #2;
        reset = 1'b0;
        #1;
        check("rw_grant",  64'(b_grant), 64'd0);
        check("rw_strobe", 64'({b_mem_re, b_mem_we}), 64'd0);
        check("rw_ack",    64'({b_if_ack, b_d_ack}), 64'd0);
        check("rw_addr",   64'(b_mem_addr), 64'd0);
        check("rw_rdata",  64'({b_if_rdata, b_d_rdata}), 64'd0);
        b_if_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        ack_cnt = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (b_if_ack || b_d_ack || b_mem_re) ack_cnt++;
        end
        check("rw_no_ack", 64'(ack_cnt), 64'd0);

        // Fresh fetch after release.
        b_if_addr = 32'h64; b_mem_val = 32'h00ABCDEF; b_if_req = 1'b1;
        ack_at = -1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (b_if_ack && ack_at < 0) begin
                ack_at = e;
                b_if_req = 1'b0;
            end
        end
        check("rw_fresh_ack_edge", 64'(ack_at), 64'd3);
        check("rw_fresh_rdata", 64'(b_if_rdata), 64'h00ABCDEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported word memory between the multicycle CPU's instruction-fetch port and its data port. It sits between the CPU and the unified memory in the computer top level. It converts each requester's req/ack handshake into a correctly timed memory strobe. Ties between simultaneous requests are resolved round-robin.

## Interface
Parameters:
- ADDR_W, 32, address width (word addresses passed through unchanged)
- DATA_W, 32, data width
- MEM_LATENCY, 1, read latency of the memory in cycles (legal range 1..7)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata valid while high
- if_rdata  out  DATA_W  fetched word, registered
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse; completion, and d_rdata valid for reads
- d_rdata  out  DATA_W  read word, registered
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered write data
- mem_re  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY edges after the mem_re edge
- grant  out  2  one-hot owner: bit0 = fetch, bit1 = data; 00 when idle

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: at an edge with any req high, pick a winner, latch its address, write data and direction, and set grant. Go to ISSUE.
  - Only one requester high: it wins.
  - Both high: the requester not granted last time wins (round-robin).
  - last_grant resets to data, so the first tie goes to fetch.
- ISSUE: exactly one cycle with mem_re or mem_we high, plus mem_addr and mem_wdata.
  - Write: next state is ACK.
  - Read with MEM_LATENCY = 1: capture mem_rdata at the ISSUE→ACK edge.
  - Read with MEM_LATENCY > 1: go to WAIT with cnt = MEM_LATENCY-1.
- WAIT: decrement cnt each edge. At the edge where cnt reaches 1, capture mem_rdata into the winner's rdata register and go to ACK.
- ACK: assert only the winner's ack for one cycle. Then go to IDLE. req is not sampled in ACK.
- Fetch port is read-only; the fetch direction is always read.
- if_rdata and d_rdata hold their last value until the next capture for that port. Writes do not alter d_rdata.
- grant stays high from ISSUE through ACK and clears on entry to IDLE.
- Requester rule: drop req (or present a new request) at the edge that ends the ACK cycle. A req still high in IDLE is treated as a new request.

## Timing
- Reset (async, reset = 0): state IDLE; grant, mem_re, mem_we, if_ack and d_ack are 0; mem_addr, mem_wdata, if_rdata and d_rdata are 0; last_grant is data; cnt is 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. Strobes clear immediately, without waiting for a clock.
- Let E0 be the edge at which req is sampled in IDLE.
  - Write: strobe during E0–E1, ack during E1–E2.
  - Read: strobe during E0–E1, data captured at edge E(MEM_LATENCY), ack during E(L)–E(L+1).
- Back-to-back: the next request is sampled no earlier than E(ack+1). Minimum issue spacing is 3 cycles for writes and MEM_LATENCY+2 cycles for reads.
- A losing requester waits one full transaction and is guaranteed service next. Starvation is impossible.
- A req that drops before ack is a protocol violation: the transaction completes and the ack is still issued.

## Structure
- Shared package cpu_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, ACK)
  - GRANT_IF = 2'b01 and GRANT_D = 2'b10
  - MEM_LATENCY default constant
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin picker with inputs req[1:0] and last and a one-hot output.
- All outputs are registered. There is no combinational path from req to any mem_* output.

## Test plan
- Fetch read, MEM_LATENCY = 1: if_req at addr 0x10, mem returns 0x8C010004 → mem_re for one cycle with mem_addr = 0x10; if_ack during E1–E2 with if_rdata = 0x8C010004; grant = 01 during E0–E2.
- Data write: d_we = 1, d_addr = 0x20, d_wdata = 0xDEADBEEF → mem_we for one cycle with that address and data; d_ack during E1–E2; d_rdata unchanged.
- Tie after reset: if_req and d_req high together, both held → fetch served first, then data. On repeated ties the order alternates F, D, F, D.
- MEM_LATENCY = 3 data read of 0x00000042 → d_ack exactly 3 edges after the strobe edge, with d_rdata = 0x42. No second mem_re in WAIT.
- Reset asserted in WAIT → all outputs 0 immediately and no ack. After release, a fresh if_req is served normally.
- Continuous fetch stream, 10 requests → exactly 10 mem_re pulses and 10 if_ack pulses, spaced MEM_LATENCY+2 cycles apart.
